// File: rtl/vga_fetch_pkg.sv
// Shared definitions for the VGA burst fetcher: FSM encoding and default sizing.
package vga_fetch_pkg;

  localparam int BURST_DEF     = 8;
  localparam int WATERMARK_DEF = 300;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DELAY     = 3'd1,
    ST_TRYCACHE  = 3'd2,
    ST_CACHE     = 3'd3,
    ST_FML_WAIT  = 3'd4,
    ST_FML_DATA  = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-tick divider: one pix_en pulse every pix_div+1 cycles, period latched at wrap.
module vga_pix_div
  import vga_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pix_div,
  output logic       pix_en
);

  logic [1:0] cnt;
  logic [1:0] period;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 2'd0;
      period <= pix_div;
    end else if (cnt == period) begin
      cnt    <= 2'd0;
      period <= pix_div;
    end else begin
      cnt    <= cnt + 2'd1;
    end
  end

  // Count 0 is the tick, so the first cycle out of reset is already a pixel tick.
  assign pix_en = !rst && (cnt == 2'd0);

endmodule

// File: rtl/vga_burst_fetch.sv
// VGA burst fetcher: tries the direct cache bus first, falls back to a DRAM burst,
// and paces the pixel FIFO read side with a programmable pixel tick.
module vga_burst_fetch
  import vga_fetch_pkg::*;
#(
  parameter int ADR_W     = 20,
  parameter int BURST     = BURST_DEF,
  parameter int LVL_W     = 10,
  parameter int WATERMARK = WATERMARK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [ADR_W-2:0] req_adr,
  input  logic [15:0]      start_addr,
  output logic [ADR_W-1:0] fml_adr,
  output logic             fml_stb,
  input  logic             fml_ack,
  output logic             dcb_stb,
  output logic [ADR_W-1:0] dcb_adr,
  input  logic             dcb_hit,
  output logic             src_cache,
  output logic             seq_en,
  input  logic [LVL_W-1:0] fifo_level,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic [1:0]       pix_div,
  output logic             pix_en,
  output logic             fifo_rd,
  output logic             underrun,
  input  logic             underrun_clr
);

  localparam int               IDX_W = $clog2(BURST);
  localparam int               WA_W  = ADR_W - 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(BURST - 1);
  localparam logic [31:0]      WM    = WATERMARK;

  fetch_state_t     state, state_nxt;
  logic [IDX_W-1:0] beat, beat_nxt;
  logic [IDX_W-1:0] idx;
  logic             level_ok;
  logic             accept;
  logic             seq_en_c, dcb_stb_c, fml_stb_c, src_cache_c;
  logic             unused_start_lsb;

  // Word offset plus the CRTC start (in 32-bit units), wrapping in the word space.
  function automatic logic [ADR_W-1:0] burst_byte_adr(input logic [WA_W-1:0] ofs,
                                                      input logic [14:0]     start_hi);
    logic [WA_W-1:0] start_w;
    start_w = WA_W'({start_hi, 2'b00});
    return {ofs + start_w, 1'b0};
  endfunction

  assign unused_start_lsb = start_addr[0];
  assign level_ok = (32'(fifo_level) <= WM) && !fifo_full;
  assign accept   = (state == ST_IDLE) && level_ok && req;

  always_comb begin
    state_nxt   = state;
    beat_nxt    = beat;
    seq_en_c    = 1'b0;
    dcb_stb_c   = 1'b0;
    fml_stb_c   = 1'b0;
    src_cache_c = 1'b0;
    case (state)
      ST_IDLE: begin
        seq_en_c = level_ok;
        if (accept) state_nxt = ST_DELAY;
      end
      ST_DELAY: begin
        seq_en_c  = 1'b1;
        state_nxt = ST_TRYCACHE;
      end
      ST_TRYCACHE: begin
        dcb_stb_c = 1'b1;
        seq_en_c  = 1'b1;
        beat_nxt  = '0;
        state_nxt = ST_CACHE;
      end
      ST_CACHE: begin
        src_cache_c = 1'b1;
        // Beat 0 is the lookup-result cycle; later beats ignore dcb_hit.
        if (beat == '0) begin
          if (dcb_hit) begin
            dcb_stb_c = 1'b1;
            seq_en_c  = 1'b1;
            beat_nxt  = beat + 1'b1;
          end else begin
            state_nxt = ST_FML_WAIT;
          end
        end else begin
          seq_en_c  = 1'b1;
          dcb_stb_c = (beat != LAST);
          beat_nxt  = beat + 1'b1;
          if (beat == LAST) state_nxt = ST_IDLE;
        end
      end
      ST_FML_WAIT: begin
        fml_stb_c = 1'b1;
        if (fml_ack) begin
          seq_en_c  = 1'b1;
          beat_nxt  = IDX_W'(1);
          state_nxt = ST_FML_DATA;
        end
      end
      ST_FML_DATA: begin
        seq_en_c = 1'b1;
        beat_nxt = beat + 1'b1;
        if (beat == LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      beat    <= '0;
      idx     <= '0;
      fml_adr <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      if (accept) fml_adr <= burst_byte_adr(req_adr, start_addr[15:1]);
      // Index tracks the burst's starting word until the cache strobe starts walking the line.
      if (dcb_stb_c) idx <= idx + 1'b1;
      else           idx <= fml_adr[IDX_W:1];
    end
  end

  assign dcb_adr   = {fml_adr[ADR_W-1:IDX_W+1], idx, 1'b0};
  assign seq_en    = seq_en_c    && !rst;
  assign dcb_stb   = dcb_stb_c   && !rst;
  assign fml_stb   = fml_stb_c   && !rst;
  assign src_cache = src_cache_c && !rst;

  vga_pix_div u_pix_div (
    .clk     (clk),
    .rst     (rst),
    .pix_div (pix_div),
    .pix_en  (pix_en)
  );

  assign fifo_rd = pix_en && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst)                        underrun <= 1'b0;
    else if (pix_en && fifo_empty)  underrun <= 1'b1;
    else if (underrun_clr)          underrun <= 1'b0;
  end

endmodule

// File: tb/tb_vga_burst_fetch.sv
// Directed bench for vga_burst_fetch: default build plus a BURST=16/ADR_W=22 build.
module tb_vga_burst_fetch;

  logic        clk;
  logic        rst, req, req16;
  logic [18:0] req_adr;
  logic [20:0] req_adr16;
  logic [15:0] start_addr;
  logic [19:0] fml_adr, dcb_adr;
  logic [21:0] fml_adr16, dcb_adr16;
  logic        fml_stb, fml_ack, dcb_stb, dcb_hit, src_cache, seq_en;
  logic        fml_stb16, dcb_stb16, src_cache16, seq_en16, pix_en16, fifo_rd16, underrun16;
  logic [9:0]  fifo_level;
  logic        fifo_full, fifo_empty;
  logic [1:0]  pix_div;
  logic        pix_en, fifo_rd, underrun, underrun_clr;

  int n_checks = 0, n_errors = 0;
  int n_seq = 0, n_dcb = 0, n_fml = 0, n_src = 0, n_both = 0;
  int n_seq16 = 0, n_dcb16 = 0, n_both16 = 0;
  int b_seq, b_dcb, b_fml, b_src, b_both, b_seq16, b_dcb16, b_both16;
  logic [21:0] dcb_log   [0:63];
  logic [21:0] dcb_log16 [0:63];

  vga_burst_fetch u_dut (
    .clk(clk), .rst(rst), .req(req), .req_adr(req_adr), .start_addr(start_addr),
    .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_ack(fml_ack), .dcb_stb(dcb_stb),
    .dcb_adr(dcb_adr), .dcb_hit(dcb_hit), .src_cache(src_cache), .seq_en(seq_en),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .pix_div(pix_div), .pix_en(pix_en), .fifo_rd(fifo_rd), .underrun(underrun),
    .underrun_clr(underrun_clr)
  );

  vga_burst_fetch #(.ADR_W(22), .BURST(16)) u_dut16 (
    .clk(clk), .rst(rst), .req(req16), .req_adr(req_adr16), .start_addr(start_addr),
    .fml_adr(fml_adr16), .fml_stb(fml_stb16), .fml_ack(fml_ack), .dcb_stb(dcb_stb16),
    .dcb_adr(dcb_adr16), .dcb_hit(dcb_hit), .src_cache(src_cache16), .seq_en(seq_en16),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .pix_div(pix_div), .pix_en(pix_en16), .fifo_rd(fifo_rd16), .underrun(underrun16),
    .underrun_clr(underrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (seq_en) n_seq++;
    if (dcb_stb) begin
      dcb_log[n_dcb % 64] = {2'b00, dcb_adr};
      n_dcb++;
    end
    if (fml_stb) n_fml++;
    if (src_cache) n_src++;
    if (fml_stb && dcb_stb) n_both++;
    if (seq_en16) n_seq16++;
    if (dcb_stb16) begin
      dcb_log16[n_dcb16 % 64] = dcb_adr16;
      n_dcb16++;
    end
    if (fml_stb16 && dcb_stb16) n_both16++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_seq = n_seq; b_dcb = n_dcb; b_fml = n_fml; b_src = n_src; b_both = n_both;
    b_seq16 = n_seq16; b_dcb16 = n_dcb16; b_both16 = n_both16;
  endtask

  // Presents one request to the default DUT; returns in the DELAY cycle with counters snapped.
  task automatic start_burst(input logic [18:0] ofs, input logic [15:0] sa, input logic hit);
    req_adr = ofs; start_addr = sa; dcb_hit = hit;
    fifo_full = 1'b0; fifo_level = 10'd0; req = 1'b1;
    tick();
    req = 1'b0; fifo_full = 1'b1;
    snap();
  endtask

  initial begin
    logic        found;
    logic [15:0] pe;
    logic        rd_any;

    rst = 1'b1; req = 1'b0; req16 = 1'b0; req_adr = '0; req_adr16 = '0; start_addr = '0;
    fml_ack = 1'b0; dcb_hit = 1'b0; fifo_level = 10'd0; fifo_full = 1'b0; fifo_empty = 1'b0;
    pix_div = 2'd0; underrun_clr = 1'b0;
    repeat (3) tick();

    check("rst_seq_en",    seq_en,    0);
    check("rst_fml_stb",   fml_stb,   0);
    check("rst_dcb_stb",   dcb_stb,   0);
    check("rst_src_cache", src_cache, 0);
    check("rst_pix_en",    pix_en,    0);
    check("rst_fifo_rd",   fifo_rd,   0);
    check("rst_underrun",  underrun,  0);
    check("rst_fml_adr",   fml_adr,   0);
    check("rst_dcb_adr",   dcb_adr,   0);

    rst = 1'b0; fifo_full = 1'b1;
    #1;
    check("first_pix_en", pix_en, 1);
    check("idle_full_no_seq", seq_en, 0);
    tick();

    // Cache hit burst
    start_burst(19'h10, 16'h0002, 1'b1);
    check("hit_fml_adr", fml_adr, 32'h28);
    repeat (16) tick();
    check("hit_seq_cnt",  n_seq - b_seq, 10);
    check("hit_dcb_cnt",  n_dcb - b_dcb, 8);
    check("hit_src_cnt",  n_src - b_src, 8);
    check("hit_fml_cnt",  n_fml - b_fml, 0);
    check("hit_overlap",  n_both - b_both, 0);
    check("hit_dcb_adr0", dcb_log[(b_dcb + 0) % 64], 32'h28);
    check("hit_dcb_adr1", dcb_log[(b_dcb + 1) % 64], 32'h2A);
    check("hit_dcb_adr4", dcb_log[(b_dcb + 4) % 64], 32'h20);
    check("hit_dcb_adr7", dcb_log[(b_dcb + 7) % 64], 32'h26);

    // Cache miss, DRAM ack after 5 wait cycles; offset wraps the word space
    start_burst(19'h7FFFF, 16'h1235, 1'b0);
    fml_ack = 1'b0;
    check("miss_fml_adr", fml_adr, 32'h048CE);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (fml_stb) found = 1'b1;
    end
    check("miss_fml_stb_seen", found, 1);
    repeat (5) tick();
    check("miss_wait_seq", n_seq - b_seq, 2);
    check("miss_stb_held", fml_stb, 1);
    fml_ack = 1'b1;
    tick();
    fml_ack = 1'b0;
    repeat (12) tick();
    check("miss_seq_cnt", n_seq - b_seq, 10);
    check("miss_fml_cnt", n_fml - b_fml, 6);
    check("miss_dcb_cnt", n_dcb - b_dcb, 1);
    check("miss_src_cnt", n_src - b_src, 1);
    check("miss_overlap", n_both - b_both, 0);

    // Watermark boundary
    fifo_full = 1'b0; fifo_level = 10'd301; req = 1'b1;
    req_adr = 19'h100; start_addr = 16'h0000; dcb_hit = 1'b1;
    snap();
    repeat (5) tick();
    check("wm301_seq",     n_seq - b_seq, 0);
    check("wm301_dcb",     n_dcb - b_dcb, 0);
    check("wm301_fml_adr", fml_adr, 32'h048CE);
    fifo_level = 10'd300;
    #1;
    check("wm300_seq_en", seq_en, 1);
    tick();
    req = 1'b0; fifo_full = 1'b1;
    snap();
    check("wm300_fml_adr", fml_adr, 32'h200);
    repeat (16) tick();
    check("wm300_seq_cnt", n_seq - b_seq, 10);

    // Pixel divider and underrun
    pix_div = 2'd3; fifo_empty = 1'b1;
    pe = '0; rd_any = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      pe[i] = pix_en;
      rd_any = rd_any | fifo_rd;
    end
    check("pix_pattern",  pe, 32'h1111);
    check("pix_no_rd",    rd_any, 0);
    check("underrun_set", underrun, 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("underrun_clr", underrun, 0);
    check("tick_aligned", pix_en, 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("underrun_set_wins", underrun, 1);
    fifo_empty = 1'b0;
    repeat (3) tick();
    check("fifo_rd_on_tick", fifo_rd, 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("underrun_clr2", underrun, 0);

    // Reset in FML_DATA beat 3
    fml_ack = 1'b1;
    start_burst(19'h20, 16'h0000, 1'b0);
    repeat (6) tick();
    check("fd3_seq_en", seq_en, 1);
    fifo_full = 1'b0; rst = 1'b1;
    snap();
    #1;
    check("rst_gate_seq", seq_en, 0);
    tick();
    fml_ack = 1'b0;
    check("mid_rst_seq_en",    seq_en,    0);
    check("mid_rst_fml_stb",   fml_stb,   0);
    check("mid_rst_dcb_stb",   dcb_stb,   0);
    check("mid_rst_src_cache", src_cache, 0);
    check("mid_rst_pix_en",    pix_en,    0);
    check("mid_rst_fifo_rd",   fifo_rd,   0);
    check("mid_rst_fml_adr",   fml_adr,   0);
    tick();
    check("mid_rst_no_strobes", (n_seq - b_seq) + (n_fml - b_fml) + (n_dcb - b_dcb), 0);
    rst = 1'b0; fifo_full = 1'b1;
    #1;
    check("post_rst_pix_en", pix_en, 1);
    tick();
    start_burst(19'h10, 16'h0002, 1'b1);
    check("fresh_fml_adr", fml_adr, 32'h28);
    repeat (16) tick();
    check("fresh_seq_cnt", n_seq - b_seq, 10);
    check("fresh_dcb_cnt", n_dcb - b_dcb, 8);

    // BURST=16, ADR_W=22 build with address wrap at 2^22
    req16 = 1'b1; req_adr16 = 21'h1FFFF0; start_addr = 16'h0010;
    dcb_hit = 1'b1; fifo_full = 1'b0; fifo_level = 10'd0;
    tick();
    req16 = 1'b0; fifo_full = 1'b1;
    snap();
    check("b16_fml_adr", fml_adr16, 32'h20);
    repeat (24) tick();
    check("b16_seq_cnt",  n_seq16 - b_seq16, 18);
    check("b16_dcb_cnt",  n_dcb16 - b_dcb16, 16);
    check("b16_dcb_first", dcb_log16[(b_dcb16 + 0) % 64], 32'h20);
    check("b16_dcb_last",  dcb_log16[(b_dcb16 + 15) % 64], 32'h3E);
    check("b16_overlap",  n_both16 - b_both16, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
